mips_alu_control: RTL and testbench
===================================

// Module: mips_alu_control
// PURPOSE
// - Issue-side driver of the 4-bit ALU control code: decodes ALUOp/opcode/funct from ID into the registered control word for EX.
// - Owns the HI/LO multiply/divide unit (iterative, multi-cycle) and stalls issue while it is busy.
// - Sits between the main decoder and the ALU; one registered output beat per accepted non-MDU instruction.
// PARAMETERS
// - XLEN    32  operand / HI / LO width
// - MDU_ITS 32  iterations per mult/div (equals XLEN)
// PORTS
// - clk         in   1     single clock, rising edge
// - reset       in   1     synchronous, active-high
// - in_valid    in   1     decode presents an instruction
// - in_ready    out  1     block can accept this cycle
// - alu_op      in   2     00 add (lw/sw/addi), 01 sub (beq/bne), 10 R-type, 11 immediate via opcode
// - opcode      in   6     used when alu_op=11 (andi 0x0C, ori 0x0D, slti 0x0A)
// - funct       in   6     used when alu_op=10
// - rs_val      in   XLEN  operand A (MDU only)
// - rt_val      in   XLEN  operand B (MDU only)
// - out_valid   out  1     registered control beat valid (exactly 1 cycle)
// - alu_ctl     out  4     0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR
// - mf_sel      out  1     beat is mfhi/mflo; EX takes mf_data instead of ALU result
// - mf_data     out  XLEN  HI or LO value for mfhi/mflo
// - mdu_busy    out  1     iterative mult/div in progress
// - illegal     out  1     undecodable funct/opcode (only with ALUCTL_ILLEGAL_EN)
// BEHAVIOUR
// - Reset: out_valid=0, alu_ctl=0, mf_sel=0, mf_data=0, mdu_busy=0, illegal=0, HI=LO=0, FSM=IDLE.
// - Handshake: accept when in_valid & in_ready; in_ready = (state==IDLE). No skid; no back-pressure on output.
// - Non-MDU accept at cycle N -> out_valid=1 with alu_ctl at N+1; out_valid=0 otherwise.
// - Funct map (alu_op=10): 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
// - Opcode map (alu_op=11): 0x0C AND, 0x0D OR, 0x0A SLT; other opcodes -> ADD.
// - mfhi 0x10 / mflo 0x12: beat with alu_ctl=2, mf_sel=1, mf_data=HI/LO sampled at accept.
// - mult 0x18, multu 0x19, div 0x1A, divu 0x1B: no output beat; FSM leaves IDLE, mdu_busy=1 from N+1.
// - FSM: IDLE -> MUL|DIV (MDU_ITS cycles, one bit/cycle) -> FIX (1 cycle: sign correction, HI/LO write) -> IDLE.
//   Busy exactly MDU_ITS+1 = 33 cycles; next instruction accepted at N+34 earliest.
// - MUL: shift-add on |A|,|B| (signed) or raw (unsigned); 64-bit product, HI=[63:32], LO=[31:0].
// - DIV: restoring on magnitudes; LO=quotient, HI=remainder; signed: quotient negated if signs differ,
//   remainder takes dividend sign. Divide by zero: LO=32'hFFFFFFFF, HI=dividend (deterministic, no trap).
// - Signed -2^31 / -1: LO=32'h80000000, HI=0.
// - mfhi/mflo issued after mult/div: stalled by in_ready=0 until FIX completes; never returns stale HI/LO.
// - Reset mid-operation: FSM to IDLE, HI/LO cleared, partial result discarded, next cycle in_ready=1.
// - Unknown funct (alu_op=10): alu_ctl=0, out_valid=1, HI/LO untouched.
// CONFIGURATION
// - ALUCTL_ILLEGAL_EN defined: unknown funct under alu_op=10 or opcode not in map under alu_op=11 ->
//   out_valid=1, alu_ctl=0, illegal=1 for that beat.
// - Not defined: illegal tied 0; unknown funct -> alu_ctl=0, unknown immediate opcode -> ADD, silently.
// STRUCTURE
// - Package mips_alu_pkg: ALU code localparams (CTL_AND..CTL_NOR), ALUOp enum, funct/opcode constants,
//   MDU state enum {IDLE, MUL, DIV, FIX}; shared with the ALU and main decoder.
// - One sub-module: mips_mdu_iter (iterative mult/div datapath + counter, start/done, HI/LO out);
//   top keeps decode, handshake, FSM sequencing and output register.
// TESTING
// - R-type sweep: alu_op=10, funct 0x20,0x22,0x24,0x25,0x27,0x2A -> next cycle alu_ctl 2,6,0,1,12,7, out_valid 1-cycle pulses.
// - mult rs=-3, rt=7 -> mdu_busy 33 cycles, in_ready=0; then mfhi -> mf_data=FFFFFFFF, mflo -> FFFFFFEB.
// - divu 100/7 -> LO=14, HI=2; div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; div 5/0 -> LO=FFFFFFFF, HI=5.
// - mfhi held on in_valid during busy -> accepted only at N+34, mf_data = new HI.
// - reset asserted at iteration 10 of mult -> next cycle mdu_busy=0, in_ready=1, mflo returns 0.
// - funct 0x3F: with ALUCTL_ILLEGAL_EN illegal=1, alu_ctl=0; without, illegal=0, alu_ctl=0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// ============================================================================
// Module      : mips_alu_pkg
// Description : Shared ALU control codes, ALUOp/funct/opcode constants, MDU
//               state encoding and the combinational control-code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_alu_pkg;

   localparam logic [3:0] CTL_AND = 4'd0;
   localparam logic [3:0] CTL_OR  = 4'd1;
   localparam logic [3:0] CTL_ADD = 4'd2;
   localparam logic [3:0] CTL_SUB = 4'd6;
   localparam logic [3:0] CTL_SLT = 4'd7;
   localparam logic [3:0] CTL_NOR = 4'd12;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_IMM   = 2'b11
   } aluOp_e;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_FIX   = 2'd3;

   typedef struct packed {
      logic [3:0] ctl;
      logic       known;
   } ctlDecode_t;

   function automatic logic isMduFunct(input logic [5:0] funct);
      return (funct == FN_MULT) || (funct == FN_MULTU) ||
             (funct == FN_DIV)  || (funct == FN_DIVU);
   endfunction

   // Unknown immediates fall back to ADD; unknown functs to AND (code 0).
   function automatic ctlDecode_t decodeCtl(input logic [1:0] aluOp,
                                            input logic [5:0] opcode,
                                            input logic [5:0] funct);
      ctlDecode_t d;
      d.ctl   = CTL_ADD;
      d.known = 1'b1;
      case (aluOp)
         ALUOP_ADD: d.ctl = CTL_ADD;
         ALUOP_SUB: d.ctl = CTL_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU, FN_MFHI, FN_MFLO: d.ctl = CTL_ADD;
               FN_SUB, FN_SUBU:                  d.ctl = CTL_SUB;
               FN_AND:                           d.ctl = CTL_AND;
               FN_OR:                            d.ctl = CTL_OR;
               FN_NOR:                           d.ctl = CTL_NOR;
               FN_SLT:                           d.ctl = CTL_SLT;
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: d.ctl = CTL_ADD;
               default: begin
                  d.ctl   = CTL_AND;
                  d.known = 1'b0;
               end
            endcase
         end
         default: begin
            case (opcode)
               OP_ANDI: d.ctl = CTL_AND;
               OP_ORI:  d.ctl = CTL_OR;
               OP_SLTI: d.ctl = CTL_SLT;
               default: begin
                  d.ctl   = CTL_ADD;
                  d.known = 1'b0;
               end
            endcase
         end
      endcase
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mdu_iter.sv
// ============================================================================
// Module      : mips_mdu_iter
// Description : Iterative one-bit-per-cycle shift-add multiplier / restoring
//               divider with HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mdu_iter #(
   parameter int XLEN    = 32,
   parameter int MDU_ITS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            isDiv,
   input  logic            isSigned,
   input  logic [XLEN-1:0] rsVal,
   input  logic [XLEN-1:0] rtVal,
   input  logic            iterate,
   input  logic            fix,
   output logic            lastIter,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = (MDU_ITS > 1) ? $clog2(MDU_ITS) : 1;

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_divisor;
   logic [XLEN-1:0]   r_dividend;
   logic [CW-1:0]     r_count;
   logic              r_isDiv;
   logic              r_negQ;
   logic              r_negR;
   logic              r_divZero;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;

   logic [XLEN-1:0]   w_magA;
   logic [XLEN-1:0]   w_magB;
   logic [XLEN:0]     w_mulSum;
   logic [XLEN:0]     w_remShift;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_step;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;

   assign w_magA = (isSigned && rsVal[XLEN-1]) ? -rsVal : rsVal;
   assign w_magB = (isSigned && rtVal[XLEN-1]) ? -rtVal : rtVal;

   // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
   assign w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
   // Divide: shift remainder:quotient left, keep the trial subtraction if it does not go negative.
   assign w_remShift = r_acc[2*XLEN-1:XLEN-1];
   assign w_trial    = w_remShift - {1'b0, r_divisor};

   always_comb begin
      w_step = {w_mulSum, r_acc[XLEN-1:1]};
      if (r_isDiv) begin
         if (w_trial[XLEN])
            w_step = {w_remShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
         else
            w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
   end

   assign w_prod = r_negQ ? -r_acc : r_acc;
   assign w_quot = r_negQ ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_negR ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_divisor  <= '0;
         r_dividend <= '0;
         r_count    <= '0;
         r_isDiv    <= 1'b0;
         r_negQ     <= 1'b0;
         r_negR     <= 1'b0;
         r_divZero  <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else if (start) begin
         r_acc      <= {{XLEN{1'b0}}, w_magA};
         r_divisor  <= w_magB;
         r_dividend <= rsVal;
         r_count    <= '0;
         r_isDiv    <= isDiv;
         r_negQ     <= isSigned & (rsVal[XLEN-1] ^ rtVal[XLEN-1]);
         r_negR     <= isSigned & rsVal[XLEN-1];
         r_divZero  <= (rtVal == '0);
      end else if (iterate) begin
         r_acc   <= w_step;
         r_count <= r_count + 1'b1;
      end else if (fix) begin
         if (!r_isDiv) begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
         end else if (r_divZero) begin
            r_hi <= r_dividend;
            r_lo <= '1;
         end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
         end
      end
   end

   assign lastIter = (r_count == CW'(MDU_ITS - 1));
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

`default_nettype wire

// File: rtl/mips_alu_control.sv
// ============================================================================
// Module      : mips_alu_control
// Description : Registered ALU control decode plus HI/LO mult/div sequencing.
//               ALUCTL_ILLEGAL_EN enables the illegal-instruction flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_control
   import mips_alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MDU_ITS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            out_valid,
   output logic [3:0]      alu_ctl,
   output logic            mf_sel,
   output logic [XLEN-1:0] mf_data,
   output logic            mdu_busy,
   output logic            illegal
);

   logic [1:0]      r_state;
   logic            r_outValid;
   logic [3:0]      r_aluCtl;
   logic            r_mfSel;
   logic [XLEN-1:0] r_mfData;

   logic            w_accept;
   logic            w_isMdu;
   logic            w_isMf;
   logic            w_beat;
   ctlDecode_t      w_dec;
   logic [3:0]      w_ctl;
   logic            w_lastIter;
   logic [XLEN-1:0] w_hi;
   logic [XLEN-1:0] w_lo;

   assign in_ready = (r_state == ST_IDLE);
   assign w_accept = in_valid & in_ready;
   assign w_isMdu  = (alu_op == ALUOP_RTYPE) && isMduFunct(funct);
   assign w_isMf   = (alu_op == ALUOP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
   assign w_beat   = w_accept & ~w_isMdu;
   assign w_dec    = decodeCtl(alu_op, opcode, funct);

`ifdef ALUCTL_ILLEGAL_EN
   logic r_illegal;
   assign w_ctl = w_dec.known ? w_dec.ctl : CTL_AND;
   always_ff @(posedge clk) begin
      if (reset) r_illegal <= 1'b0;
      else       r_illegal <= w_beat & ~w_dec.known;
   end
   assign illegal = r_illegal;
`else
   assign w_ctl   = w_dec.ctl;
   assign illegal = 1'b0;
`endif

   mips_mdu_iter #(
      .XLEN    (XLEN),
      .MDU_ITS (MDU_ITS)
   ) u_mdu (
      .clk      (clk),
      .reset    (reset),
      .start    (w_accept & w_isMdu),
      .isDiv    (funct[1]),
      .isSigned (~funct[0]),
      .rsVal    (rs_val),
      .rtVal    (rt_val),
      .iterate  ((r_state == ST_MUL) || (r_state == ST_DIV)),
      .fix      (r_state == ST_FIX),
      .lastIter (w_lastIter),
      .hi       (w_hi),
      .lo       (w_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_accept && w_isMdu) r_state <= funct[1] ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (w_lastIter) r_state <= ST_FIX;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_outValid <= 1'b0;
         r_aluCtl   <= '0;
         r_mfSel    <= 1'b0;
         r_mfData   <= '0;
      end else begin
         r_outValid <= w_beat;
         r_mfSel    <= w_beat & w_isMf;
         if (w_beat) begin
            r_aluCtl <= w_ctl;
            if (w_isMf) r_mfData <= (funct == FN_MFHI) ? w_hi : w_lo;
         end
      end
   end

   assign out_valid = r_outValid;
   assign alu_ctl   = r_aluCtl;
   assign mf_sel    = r_mfSel;
   assign mf_data   = r_mfData;
   assign mdu_busy  = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_control.sv
// ============================================================================
// Module      : tb_mips_alu_control
// Description : Directed vector table plus multi-cycle MDU sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_control;
   import mips_alu_pkg::*;

`ifdef ALUCTL_ILLEGAL_EN
   localparam bit ILL = 1'b1;
`else
   localparam bit ILL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  alu_op = 2'b00;
   logic [5:0]  opcode = 6'h00;
   logic [5:0]  funct = 6'h00;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        out_valid;
   logic [3:0]  alu_ctl;
   logic        mf_sel;
   logic [31:0] mf_data;
   logic        mdu_busy;
   logic        illegal;

   int nCmp = 0;
   int nErr = 0;

   mips_alu_control #(.XLEN(32), .MDU_ITS(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .opcode    (opcode),
      .funct     (funct),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .out_valid (out_valid),
      .alu_ctl   (alu_ctl),
      .mf_sel    (mf_sel),
      .mf_data   (mf_data),
      .mdu_busy  (mdu_busy),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] aluOp;
      logic [5:0] opc;
      logic [5:0] fn;
      logic [3:0] ctl;
      logic       ill;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge.
   task automatic beat(input string nm, input logic [1:0] op, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [3:0] expCtl, input logic expMf,
                       input logic [31:0] expData, input logic expIll);
      alu_op = op; opcode = opc; funct = fn; in_valid = 1'b1;
      chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({nm, " out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " alu_ctl"}, 64'(alu_ctl), 64'(expCtl));
      chk({nm, " mf_sel"}, 64'(mf_sel), 64'(expMf));
      if (expMf) chk({nm, " mf_data"}, 64'(mf_data), 64'(expData));
      chk({nm, " illegal"}, 64'(illegal), 64'(expIll));
      @(negedge clk);
      chk({nm, " pulse end"}, 64'(out_valid), 64'd0);
   endtask

   task automatic mduRun(input string nm, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
      int busy;
      int bad;
      alu_op = ALUOP_RTYPE; funct = fn; rs_val = a; rt_val = b; in_valid = 1'b1;
      chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      busy = 0; bad = 0;
      while (mdu_busy && busy < 100) begin
         busy++;
         if (in_ready || out_valid) bad++;
         @(negedge clk);
      end
      chk({nm, " busy cycles"}, 64'(busy), 64'd33);
      chk({nm, " stall violations"}, 64'(bad), 64'd0);
      beat({nm, " mfhi"}, ALUOP_RTYPE, 6'h00, FN_MFHI, CTL_ADD, 1'b1, expHi, 1'b0);
      beat({nm, " mflo"}, ALUOP_RTYPE, 6'h00, FN_MFLO, CTL_ADD, 1'b1, expLo, 1'b0);
   endtask

   initial begin
      int cnt;
      vecs[0]  = '{ALUOP_RTYPE, 6'h00, 6'h20, 4'd2,  1'b0};
      vecs[1]  = '{ALUOP_RTYPE, 6'h00, 6'h22, 4'd6,  1'b0};
      vecs[2]  = '{ALUOP_RTYPE, 6'h00, 6'h24, 4'd0,  1'b0};
      vecs[3]  = '{ALUOP_RTYPE, 6'h00, 6'h25, 4'd1,  1'b0};
      vecs[4]  = '{ALUOP_RTYPE, 6'h00, 6'h27, 4'd12, 1'b0};
      vecs[5]  = '{ALUOP_RTYPE, 6'h00, 6'h2A, 4'd7,  1'b0};
      vecs[6]  = '{ALUOP_RTYPE, 6'h00, 6'h21, 4'd2,  1'b0};
      vecs[7]  = '{ALUOP_RTYPE, 6'h00, 6'h23, 4'd6,  1'b0};
      vecs[8]  = '{ALUOP_ADD,   6'h23, 6'h3F, 4'd2,  1'b0};
      vecs[9]  = '{ALUOP_SUB,   6'h04, 6'h3F, 4'd6,  1'b0};
      vecs[10] = '{ALUOP_IMM,   6'h0C, 6'h00, 4'd0,  1'b0};
      vecs[11] = '{ALUOP_IMM,   6'h0D, 6'h00, 4'd1,  1'b0};
      vecs[12] = '{ALUOP_IMM,   6'h0A, 6'h00, 4'd7,  1'b0};
      vecs[13] = '{ALUOP_RTYPE, 6'h00, 6'h3F, 4'd0,  ILL};
      vecs[14] = '{ALUOP_IMM,   6'h08, 6'h00, ILL ? 4'd0 : 4'd2, ILL};
      vecs[15] = '{ALUOP_RTYPE, 6'h00, 6'h2A, 4'd7,  1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset alu_ctl", 64'(alu_ctl), 64'd0);
      chk("reset mf_sel", 64'(mf_sel), 64'd0);
      chk("reset mf_data", 64'(mf_data), 64'd0);
      chk("reset mdu_busy", 64'(mdu_busy), 64'd0);
      chk("reset illegal", 64'(illegal), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 16; i++)
         beat($sformatf("vec%0d", i), vecs[i].aluOp, vecs[i].opc, vecs[i].fn,
              vecs[i].ctl, 1'b0, 32'h0, vecs[i].ill);

      beat("mflo after reset", ALUOP_RTYPE, 6'h00, FN_MFLO, CTL_ADD, 1'b1, 32'h0, 1'b0);
      mduRun("mult -3*7", FN_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      mduRun("multu", FN_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
      mduRun("divu 100/7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      mduRun("div -7/2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      mduRun("div 5/0", FN_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
      mduRun("div min/-1", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

      // mfhi held on in_valid right behind a mult: must stall until the result is written.
      alu_op = ALUOP_RTYPE; funct = FN_MULT; rs_val = 32'h00010001; rt_val = 32'h00030000;
      in_valid = 1'b1;
      @(negedge clk);
      funct = FN_MFHI;
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      in_valid = 1'b0;
      chk("held mfhi latency", 64'(cnt), 64'd34);
      chk("held mfhi mf_sel", 64'(mf_sel), 64'd1);
      chk("held mfhi data", 64'(mf_data), 64'h3);
      @(negedge clk);
      chk("held mfhi pulse end", 64'(out_valid), 64'd0);
      beat("held mflo", ALUOP_RTYPE, 6'h00, FN_MFLO, CTL_ADD, 1'b1, 32'h00030000, 1'b0);

      // Reset partway through a mult discards it and clears HI/LO.
      alu_op = ALUOP_RTYPE; funct = FN_MULT; rs_val = 32'd5; rt_val = 32'd5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre-reset busy", 64'(mdu_busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid-op reset busy", 64'(mdu_busy), 64'd0);
      chk("mid-op reset ready", 64'(in_ready), 64'd1);
      beat("mflo after abort", ALUOP_RTYPE, 6'h00, FN_MFLO, CTL_ADD, 1'b1, 32'h0, 1'b0);
      beat("mfhi after abort", ALUOP_RTYPE, 6'h00, FN_MFHI, CTL_ADD, 1'b1, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule

`default_nettype wire
